load_store_multiple_sequencer: RTL

//  Multi-cycle sequencer for Thumb LDM/STM/PUSH/POP, replacing the fixed 8-cycle walk in the controller.

---
 rtl/load_store_multiple_sequencer_pkg.sv | 22 ++
 rtl/load_store_multiple_sequencer_lowest_set_bit_encoder.sv | 24 ++
 rtl/load_store_multiple_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/load_store_multiple_sequencer_pkg.sv
// Shared types for the LDM/STM/PUSH/POP sequencer: transfer direction,
// addressing mode and FSM state encodings.
package load_store_multiple_sequencer_pkg;

  typedef enum logic {
    LSM_LOAD  = 1'b0,
    LSM_STORE = 1'b1
  } lsm_dir_t;

  typedef enum logic {
    LSM_INC_AFTER  = 1'b0,
    LSM_DEC_BEFORE = 1'b1
  } lsm_addr_mode_t;

  typedef enum logic [1:0] {
    LSM_IDLE = 2'd0,
    LSM_XFER = 2'd1,
    LSM_WB   = 2'd2,
    LSM_DONE = 2'd3
  } lsm_state_t;

endpackage

// File: rtl/load_store_multiple_sequencer_lowest_set_bit_encoder.sv
// Combinational lowest-set-bit encoder: reports whether any bit is set and
// the index of the least significant one.
module lowest_set_bit_encoder #(
  parameter int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] list,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (list[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/load_store_multiple_sequencer.sv
// Multi-cycle LDM/STM/PUSH/POP sequencer: walks only the set bits of the
// register list, generates per-transfer offsets and an optional base writeback.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// LSM_IDLE | waiting for start_i; stall follows start_i combinationally
// LSM_XFER | presenting one transfer per accepted mem_ready_i
// LSM_WB   | single-cycle base register writeback
// LSM_DONE | one-cycle completion pulse, pipeline released
module load_store_multiple_sequencer
  import load_store_multiple_sequencer_pkg::*;
#(
  parameter int REG_LIST_WIDTH = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int WORD_BYTES     = 4,
  localparam int OFF_W         = $clog2(REG_LIST_WIDTH * WORD_BYTES) + 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic                      dir_i,
  input  logic                      addr_mode_i,
  input  logic                      writeback_i,
  input  logic [ADDR_WIDTH-1:0]     base_reg_i,
  input  logic [REG_LIST_WIDTH-1:0] reg_list_i,
  input  logic                      mem_ready_i,
  output logic                      busy_o,
  output logic                      stall_pipeline_o,
  output logic                      xfer_valid_o,
  output logic [ADDR_WIDTH-1:0]     xfer_reg_addr_o,
  output logic [OFF_W-1:0]          xfer_offset_o,
  output logic                      mem_write_en_o,
  output logic                      reg_write_en_o,
  output logic                      wb_valid_o,
  output logic [ADDR_WIDTH-1:0]     wb_reg_addr_o,
  output logic [OFF_W-1:0]          wb_offset_o,
  output logic                      done_o
);

  localparam int CNT_W = $clog2(REG_LIST_WIDTH + 1);
  localparam int IDX_W = (REG_LIST_WIDTH > 1) ? $clog2(REG_LIST_WIDTH) : 1;
  localparam logic [OFF_W-1:0] WORD_OFF = OFF_W'(WORD_BYTES);

  lsm_state_t            state;
  lsm_dir_t              dir_q;
  lsm_addr_mode_t        mode_q;
  logic                  wb_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [REG_LIST_WIDTH-1:0] list_q;
  logic [CNT_W-1:0]      n_q;
  logic [CNT_W-1:0]      k_q;

  logic                  enc_found;
  logic [IDX_W-1:0]      enc_index;
  logic                  last_bit;
  logic                  base_in_list;
  logic [REG_LIST_WIDTH-1:0] base_onehot;
  logic [OFF_W-1:0]      k_off;
  logic [OFF_W-1:0]      n_off;

  lowest_set_bit_encoder #(.WIDTH(REG_LIST_WIDTH)) u_lsb_enc (
    .list  (list_q),
    .found (enc_found),
    .index (enc_index)
  );

  assign last_bit     = ((list_q & (list_q - 1'b1)) == '0);
  assign base_onehot  = {{(REG_LIST_WIDTH-1){1'b0}}, 1'b1} << base_reg_i;
  assign base_in_list = |(reg_list_i & base_onehot);
  assign k_off        = OFF_W'(k_q) * WORD_OFF;
  assign n_off        = OFF_W'(n_q) * WORD_OFF;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state  <= LSM_IDLE;
      dir_q  <= LSM_LOAD;
      mode_q <= LSM_INC_AFTER;
      wb_q   <= 1'b0;
      base_q <= '0;
      list_q <= '0;
      n_q    <= '0;
      k_q    <= '0;
    end else begin
      case (state)
        LSM_IDLE: begin
          if (start_i) begin
            dir_q  <= lsm_dir_t'(dir_i);
            mode_q <= lsm_addr_mode_t'(addr_mode_i);
            // A base register that is also loaded keeps the loaded value.
            wb_q   <= writeback_i & ~((dir_i == LSM_LOAD) & base_in_list);
            base_q <= base_reg_i;
            list_q <= reg_list_i;
            n_q    <= CNT_W'($countones(reg_list_i));
            k_q    <= '0;
            state  <= (|reg_list_i) ? LSM_XFER : LSM_DONE;
          end
        end
        LSM_XFER: begin
          if (mem_ready_i) begin
            list_q <= list_q & (list_q - 1'b1);
            k_q    <= k_q + 1'b1;
            if (last_bit) state <= wb_q ? LSM_WB : LSM_DONE;
          end
        end
        LSM_WB:   state <= LSM_DONE;
        LSM_DONE: state <= LSM_IDLE;
        default:  state <= LSM_IDLE;
      endcase
    end
  end

  assign busy_o           = (state != LSM_IDLE);
  assign stall_pipeline_o = (state == LSM_IDLE) ? start_i
                                                : ((state == LSM_XFER) || (state == LSM_WB));
  assign xfer_valid_o     = (state == LSM_XFER) && enc_found;
  assign xfer_reg_addr_o  = xfer_valid_o ? ADDR_WIDTH'(enc_index) : '0;
  assign xfer_offset_o    = !xfer_valid_o               ? '0 :
                            (mode_q == LSM_INC_AFTER)   ? k_off : (k_off - n_off);
  assign mem_write_en_o   = xfer_valid_o && (dir_q == LSM_STORE);
  assign reg_write_en_o   = xfer_valid_o && (dir_q == LSM_LOAD);
  assign wb_valid_o       = (state == LSM_WB);
  assign wb_reg_addr_o    = wb_valid_o ? base_q : '0;
  assign wb_offset_o      = !wb_valid_o                 ? '0 :
                            (mode_q == LSM_INC_AFTER)   ? n_off : (OFF_W'(0) - n_off);
  assign done_o           = (state == LSM_DONE);

endmodule
